// File: rtl/timer_reload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_reload_ctrl
// Purpose  : Prescaled one-shot/periodic controller for an external loadable
//            up-counter (IDLE -> ARM -> RUN).
// Revision : 1.0
// ============================================================================
module timer_reload_ctrl #(
    parameter int bit_width = 64,
    parameter int pre_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [pre_width-1:0] prescale,
    input  logic [bit_width-1:0] reload_val,
    input  logic [bit_width-1:0] term_val,
    input  logic [bit_width-1:0] cnt_in,
    output logic                 cnt_clk_en,
    output logic                 cnt_load_en,
    output logic [bit_width-1:0] cnt_dIN,
    output logic                 busy,
    output logic                 expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [pre_width-1:0] c_pre_one = {{(pre_width-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next;
    logic                 r_mode;
    logic [pre_width-1:0] r_pre;
    logic [pre_width-1:0] r_presc;
    logic [bit_width-1:0] r_reload;
    logic [bit_width-1:0] r_term;
    logic                 r_expired;

    logic w_tick;
    logic w_terminal;
    logic w_accept;

    assign w_accept   = (r_state == IDLE) && start && !stop;
    assign w_tick     = (r_state == RUN) && (r_presc == r_pre);
    assign w_terminal = w_tick && (cnt_in == r_term);

    always_comb begin
        w_next      = r_state;
        cnt_clk_en  = 1'b0;
        cnt_load_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = ARM;
            end
            ARM: begin
                if (stop) begin
                    w_next = IDLE;
                end else begin
                    cnt_clk_en  = 1'b1;
                    cnt_load_en = 1'b1;
                    w_next      = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next = IDLE;
                end else if (w_tick) begin
                    if (!w_terminal) begin
                        cnt_clk_en = 1'b1;
                    end else if (r_mode) begin
                        // Periodic: reload in the terminal cycle itself.
                        cnt_clk_en  = 1'b1;
                        cnt_load_en = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            cnt_clk_en  = 1'b0;
            cnt_load_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= 1'b0;
            r_pre     <= '0;
            r_presc   <= '0;
            r_reload  <= '0;
            r_term    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_expired <= w_terminal && !stop;
            if (w_accept) begin
                r_mode   <= mode;
                r_pre    <= prescale;
                r_reload <= reload_val;
                r_term   <= term_val;
            end
            if (r_state == RUN && !w_tick) begin
                r_presc <= r_presc + c_pre_one;
            end else begin
                r_presc <= '0;
            end
        end
    end

    assign cnt_dIN = r_reload;
    assign busy    = (r_state != IDLE);
    assign expired = r_expired;

endmodule
`default_nettype wire
